dds_cmd_loader: RTL



---
 rtl/dds_cmd_loader.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/dds_cmd_loader.sv
// Sequences one AD9910 register transaction into the byte-oriented SPI engine.
// Latency: accept to o_Resp_Valid = 2 + 2*(Len+1) + 1 + engine done cycles (no ack stalls).
// Backpressure: one transaction in flight; o_Req_Ready is high only in IDLE, requests elsewhere are ignored.
//
// Ports:
//   i_Clk / i_Rst_n                      clock, asynchronous active-low reset
//   i_Req_* / o_Req_Ready                request handshake (read flag, 5-bit addr, 4-bit len, 64-bit data)
//   o_TxBuffer / o_StatusReg / o_Cmd_Lim engine command side (byte, flags Reset/Data/Rece/Send, frame length)
//   i_StatusReg / i_Tx_Cnt / i_RxBuffer  engine status side (bit7 done, bytes loaded, last rx byte)
//   o_Resp_Valid / o_Resp_Data / o_Resp_Err  one-cycle completion pulse, read byte, error flag
//
// Build option: define DDS_LOADER_TIMEOUT_EN to add a per-wait-state watchdog of
// TIMEOUT_CYCLES cycles in ACK and DONE; without it those states wait forever.
module dds_cmd_loader #(
  parameter int MAX_BYTES      = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Req_Valid,
  output logic        o_Req_Ready,
  input  logic        i_Req_Read,
  input  logic [4:0]  i_Req_Addr,
  input  logic [3:0]  i_Req_Len,
  input  logic [63:0] i_Req_Data,
  output logic [7:0]  o_TxBuffer,
  output logic [7:0]  o_StatusReg,
  output logic [7:0]  o_Cmd_Lim,
  input  logic [7:0]  i_StatusReg,
  input  logic [7:0]  i_Tx_Cnt,
  input  logic [7:0]  i_RxBuffer,
  output logic        o_Resp_Valid,
  output logic [7:0]  o_Resp_Data,
  output logic        o_Resp_Err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_LOAD  = 3'd2,
    S_ACK   = 3'd3,
    S_SEND  = 3'd4,
    S_DONE  = 3'd5,
    S_RESP  = 3'd6,
    S_ABORT = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic        read_q, read_d;
  logic [4:0]  addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic [63:0] data_sh_q, data_sh_d;   // next data byte to send always sits in [63:56]
  logic [3:0]  k_q, k_d;               // byte index within the frame, 0 = instruction
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  cmd_lim_q, cmd_lim_d;
  logic [7:0]  resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;
  logic        len_bad;
  logic        tmo_hit;

  // Only the done bit of the engine status is meaningful here.
  logic unused_status;
  assign unused_status = ^i_StatusReg[6:0];

  assign len_bad = (i_Req_Len == 4'd0) || (int'(i_Req_Len) > MAX_BYTES);

`ifdef DDS_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q, tmo_d;

  // Counts consecutive cycles spent waiting in ACK or DONE; any state change restarts it.
  always_comb begin
    tmo_d = '0;
    if (((state_q == S_ACK) || (state_q == S_DONE)) && (state_d == state_q)) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
  assign tmo_hit    = 1'b0;
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    read_d      = read_q;
    addr_d      = addr_q;
    len_d       = len_q;
    data_sh_d   = data_sh_q;
    k_d         = k_q;
    tx_d        = tx_q;
    cmd_lim_d   = cmd_lim_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;

    case (state_q)
      S_IDLE: begin
        if (i_Req_Valid) begin
          read_d      = i_Req_Read;
          addr_d      = i_Req_Addr;
          len_d       = i_Req_Len;
          data_sh_d   = i_Req_Data;
          k_d         = 4'd0;
          cmd_lim_d   = {4'd0, i_Req_Len} + 8'd1;
          resp_data_d = 8'h00;
          resp_err_d  = len_bad;
          state_d     = len_bad ? S_RESP : S_CLR;
        end
      end
      S_CLR: begin
        tx_d    = {read_q, 2'b00, addr_q};
        state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_ACK;
      end
      S_ACK: begin
        if (i_Tx_Cnt == ({4'd0, k_q} + 8'd1)) begin
          k_d = k_q + 4'd1;
          // Data byte k-1 has just been taken; expose the next one.
          if (k_q != 4'd0) begin
            data_sh_d = {data_sh_q[55:0], 8'h00};
          end
          if (k_d == (len_q + 4'd1)) begin
            state_d = S_SEND;
          end else begin
            tx_d    = read_q ? 8'h00 : data_sh_d[63:56];
            state_d = S_LOAD;
          end
        end else if (tmo_hit) begin
          state_d = S_ABORT;
        end
      end
      S_SEND: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (i_StatusReg[7]) begin
          if (read_q) begin
            resp_data_d = i_RxBuffer;
          end
          state_d = S_RESP;
        end else if (tmo_hit) begin
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        resp_err_d = 1'b1;
        state_d    = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Engine flags are decoded from state so reset clears them on the same edge.
  always_comb begin
    o_Req_Ready  = 1'b0;
    o_StatusReg  = 8'h00;
    o_Resp_Valid = 1'b0;
    case (state_q)
      S_IDLE:  o_Req_Ready  = 1'b1;
      S_CLR:   o_StatusReg  = 8'h01;
      S_LOAD:  o_StatusReg  = 8'h02;
      S_SEND:  o_StatusReg  = read_q ? 8'h0C : 8'h08;
      S_ABORT: o_StatusReg  = 8'h01;
      S_RESP:  o_Resp_Valid = 1'b1;
      default: o_StatusReg  = 8'h00;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= S_IDLE;
      read_q      <= 1'b0;
      addr_q      <= 5'd0;
      len_q       <= 4'd0;
      data_sh_q   <= 64'd0;
      k_q         <= 4'd0;
      tx_q        <= 8'h00;
      cmd_lim_q   <= 8'h00;
      resp_data_q <= 8'h00;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      read_q      <= read_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      data_sh_q   <= data_sh_d;
      k_q         <= k_d;
      tx_q        <= tx_d;
      cmd_lim_q   <= cmd_lim_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign o_TxBuffer  = tx_q;
  assign o_Cmd_Lim   = cmd_lim_q;
  assign o_Resp_Data = resp_data_q;
  assign o_Resp_Err  = resp_err_q;

endmodule
